// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the reset sequencer and its button debouncer.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ASSERT    = 2'd0,
    WAIT_LOCK = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    POR      = 2'b00,
    MANUAL   = 2'b01,
    LOCKLOSS = 2'b10
  } cause_t;

  // Width of a counter that must hold 0..max_val; never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchroniser followed by a saturating debounce counter.
// trig pulses once per stable-high episode; held stays high while it remains saturated.
module sync_debounce
  import reset_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic clk,
  input  logic nrst,
  input  logic din,
  output logic trig,
  output logic held
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);

  logic          meta_q, meta_d;
  logic          sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          trig_q, trig_d;

  // trig is registered so it fires on the edge the counter saturates.
  always_comb begin
    meta_d = din;
    sync_d = meta_q;
    cnt_d  = '0;
    trig_d = 1'b0;
    if (sync_q) begin
      cnt_d  = (cnt_q == CW'(DEBOUNCE_CYCLES)) ? cnt_q : cnt_q + 1'b1;
      trig_d = (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      cnt_q  <= '0;
      trig_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      trig_q <= trig_d;
    end
  end

  assign trig = trig_q;
  assign held = sync_q && (cnt_q == CW'(DEBOUNCE_CYCLES));

endmodule

// File: rtl/reset_sequencer.sv
// Power-on / manual reset controller: holds all domains in reset, waits for PLL lock,
// then releases the stages in order. Manual trigger or lock loss restarts the sequence.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_STAGES      = 3,
  parameter int NUM_BUTTONS     = 3,
  parameter int HOLD_CYCLES     = 4,
  parameter int STAGE_GAP       = 2,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic [NUM_BUTTONS-1:0] manual,
  input  logic                   pll_lock,
  output logic [NUM_STAGES-1:0]  rst_out,
  output logic                   busy,
  output logic [1:0]             cause
);

  localparam int HOLD_W  = cnt_width(HOLD_CYCLES);
  localparam int GAP_MAX = (NUM_STAGES - 1) * STAGE_GAP;
  localparam int GAP_W   = cnt_width(GAP_MAX);

  state_t                state_q, state_d;
  cause_t                cause_q, cause_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic [NUM_STAGES-1:0] rst_q, rst_d;
  logic                  lock_meta_q, lock_meta_d;
  logic                  lock_s_q, lock_s_d;
  logic                  man_combo, man_trig, man_held;

  assign man_combo = &manual;

  sync_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_man_debounce (
    .clk  (clk),
    .nrst (nrst),
    .din  (man_combo),
    .trig (man_trig),
    .held (man_held)
  );

  // gap_q counts edges since RELEASE was entered; stage i drops when it reaches i*STAGE_GAP.
  always_comb begin
    lock_meta_d = pll_lock;
    lock_s_d    = lock_meta_q;
    state_d     = state_q;
    cause_d     = cause_q;
    hold_d      = hold_q;
    gap_d       = gap_q;
    rst_d       = rst_q;

    unique case (state_q)
      ASSERT: begin
        rst_d = '1;
        gap_d = '0;
        if (hold_q != HOLD_W'(HOLD_CYCLES)) hold_d = hold_q + 1'b1;
        if ((hold_d == HOLD_W'(HOLD_CYCLES)) && !man_held) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        rst_d = '1;
        if (lock_s_q) begin
          rst_d[0] = 1'b0;
          gap_d    = GAP_W'(1);
          state_d  = (NUM_STAGES == 1) ? RUN : RELEASE;
        end
      end
      RELEASE: begin
        for (int i = 1; i < NUM_STAGES; i++) begin
          if (int'(gap_q) == i * STAGE_GAP) rst_d[i] = 1'b0;
        end
        if (int'(gap_q) >= GAP_MAX) state_d = RUN;
        else                        gap_d   = gap_q + 1'b1;
      end
      RUN: begin
        rst_d = '0;
      end
      default: begin
        state_d = ASSERT;
        rst_d   = '1;
      end
    endcase

    // Manual trigger takes priority over lock loss when both land together.
    if ((state_q != ASSERT) && man_trig) begin
      state_d = ASSERT;
      cause_d = MANUAL;
      rst_d   = '1;
      hold_d  = '0;
      gap_d   = '0;
    end else if (((state_q == RELEASE) || (state_q == RUN)) && !lock_s_q) begin
      state_d = ASSERT;
      cause_d = LOCKLOSS;
      rst_d   = '1;
      hold_d  = '0;
      gap_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= ASSERT;
      cause_q     <= POR;
      hold_q      <= '0;
      gap_q       <= '0;
      rst_q       <= '1;
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cause_q     <= cause_d;
      hold_q      <= hold_d;
      gap_q       <= gap_d;
      rst_q       <= rst_d;
      lock_meta_q <= lock_meta_d;
      lock_s_q    <= lock_s_d;
    end
  end

  assign rst_out = rst_q;
  assign busy    = (state_q != RUN);
  assign cause   = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer at default parameters; expected values are hand-derived
// edge by edge, with edge 1 being the first rising edge after nrst goes high.
module tb_reset_sequencer;
  import reset_seq_pkg::*;

  logic       clk;
  logic       nrst;
  logic [2:0] manual;
  logic       pll_lock;
  logic [2:0] rst_out;
  logic       busy;
  logic [1:0] cause;

  int checks = 0;
  int errors = 0;

  reset_sequencer #(
    .NUM_STAGES(3),
    .NUM_BUTTONS(3),
    .HOLD_CYCLES(4),
    .STAGE_GAP(2),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk      (clk),
    .nrst     (nrst),
    .manual   (manual),
    .pll_lock (pll_lock),
    .rst_out  (rst_out),
    .busy     (busy),
    .cause    (cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic n, input logic [2:0] m, input logic l);
    nrst     = n;
    manual   = m;
    pll_lock = l;
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  task automatic checkAll(input string tag, input logic [2:0] e_rst, input logic e_busy, input logic [1:0] e_cause);
    checkOutput({tag, "_rst"},   8'(rst_out), 8'(e_rst));
    checkOutput({tag, "_busy"},  8'(busy),    8'(e_busy));
    checkOutput({tag, "_cause"}, 8'(cause),   8'(e_cause));
  endtask

  task automatic checkState(input string tag, input state_t e_state);
    checkOutput({tag, "_state"}, 8'(dut.state_q), 8'(e_state));
  endtask

  initial begin
    // Power-on with lock present.
    applyStimulus(1'b0, 3'b000, 1'b1);
    tick(2);
    checkAll("por_in_reset", 3'b111, 1'b1, 2'b00);
    checkState("por_in_reset", ASSERT);
    applyStimulus(1'b1, 3'b000, 1'b1);
    tick(4);
    checkAll("por_e4", 3'b111, 1'b1, 2'b00);
    checkState("por_e4", WAIT_LOCK);
    tick(1);
    checkAll("por_e5", 3'b110, 1'b1, 2'b00);
    tick(1);
    checkAll("por_e6", 3'b110, 1'b1, 2'b00);
    tick(1);
    checkAll("por_e7", 3'b100, 1'b1, 2'b00);
    tick(1);
    checkAll("por_e8", 3'b100, 1'b1, 2'b00);
    tick(1);
    checkAll("por_e9", 3'b000, 1'b0, 2'b00);

    // Late lock: nothing releases until 3 edges after pll_lock rises.
    applyStimulus(1'b0, 3'b000, 1'b0);
    tick(2);
    checkAll("late_in_reset", 3'b111, 1'b1, 2'b00);
    applyStimulus(1'b1, 3'b000, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick(1);
      checkOutput("late_wait_rst", 8'(rst_out), 8'h07);
    end
    checkState("late_e20", WAIT_LOCK);
    pll_lock = 1'b1;
    tick(2);
    checkAll("late_e22", 3'b111, 1'b1, 2'b00);
    tick(1);
    checkAll("late_e23", 3'b110, 1'b1, 2'b00);
    tick(2);
    checkAll("late_e25", 3'b100, 1'b1, 2'b00);
    tick(2);
    checkAll("late_e27", 3'b000, 1'b0, 2'b00);

    // Short glitch in RUN never saturates the debouncer.
    manual = 3'b111;
    tick(5);
    manual = 3'b000;
    tick(10);
    checkAll("glitch", 3'b000, 1'b0, 2'b00);

    // One button missing from the combo never triggers.
    manual = 3'b011;
    tick(14);
    manual = 3'b000;
    tick(2);
    checkAll("partial_combo", 3'b000, 1'b0, 2'b00);

    // 12-cycle press: trigger after 2 sync + 8 debounce edges, outputs high on edge 11.
    manual = 3'b111;
    tick(10);
    checkAll("press12_e10", 3'b000, 1'b0, 2'b00);
    tick(1);
    checkAll("press12_e11", 3'b111, 1'b1, 2'b01);
    tick(1);
    manual = 3'b000;
    tick(3);
    checkAll("press12_e15", 3'b111, 1'b1, 2'b01);
    checkState("press12_e15", WAIT_LOCK);
    tick(1);
    checkAll("press12_e16", 3'b110, 1'b1, 2'b01);
    tick(4);
    checkAll("press12_e20", 3'b000, 1'b0, 2'b01);

    // 20-cycle press: ASSERT is held until the synced combo drops.
    manual = 3'b111;
    tick(11);
    checkAll("press20_e11", 3'b111, 1'b1, 2'b01);
    tick(9);
    manual = 3'b000;
    tick(2);
    checkAll("press20_e22", 3'b111, 1'b1, 2'b01);
    checkState("press20_e22", ASSERT);
    tick(1);
    checkState("press20_e23", WAIT_LOCK);
    tick(1);
    checkAll("press20_e24", 3'b110, 1'b1, 2'b01);
    tick(4);
    checkAll("press20_e28", 3'b000, 1'b0, 2'b01);

    // Lock loss mid-RELEASE.
    applyStimulus(1'b0, 3'b000, 1'b1);
    tick(2);
    checkAll("ll_in_reset", 3'b111, 1'b1, 2'b00);
    applyStimulus(1'b1, 3'b000, 1'b1);
    tick(5);
    checkAll("ll_e5", 3'b110, 1'b1, 2'b00);
    pll_lock = 1'b0;
    tick(2);
    checkAll("ll_e7", 3'b100, 1'b1, 2'b00);
    tick(1);
    checkAll("ll_e8", 3'b111, 1'b1, 2'b10);
    pll_lock = 1'b1;
    tick(4);
    checkAll("ll_e12", 3'b111, 1'b1, 2'b10);
    checkState("ll_e12", WAIT_LOCK);
    tick(1);
    checkAll("ll_e13", 3'b110, 1'b1, 2'b10);
    tick(4);
    checkAll("ll_e17", 3'b000, 1'b0, 2'b10);

    // Manual trigger and lock loss on the same edge in RUN: manual wins.
    manual = 3'b111;
    tick(8);
    pll_lock = 1'b0;
    tick(2);
    checkAll("simul_e10", 3'b000, 1'b0, 2'b10);
    tick(1);
    checkAll("simul_e11", 3'b111, 1'b1, 2'b01);
    manual   = 3'b000;
    pll_lock = 1'b1;
    tick(4);
    checkState("simul_e15", WAIT_LOCK);
    tick(1);
    checkAll("simul_e16", 3'b110, 1'b1, 2'b01);

    // Asynchronous reset pulse between clock edges, mid-RELEASE.
    nrst = 1'b0;
    #2;
    checkAll("async_pulse", 3'b111, 1'b1, 2'b00);
    checkState("async_pulse", ASSERT);
    #2;
    nrst = 1'b1;
    tick(4);
    checkAll("async_e4", 3'b111, 1'b1, 2'b00);
    checkState("async_e4", WAIT_LOCK);
    tick(1);
    checkAll("async_e5", 3'b110, 1'b1, 2'b00);
    tick(2);
    checkAll("async_e7", 3'b100, 1'b1, 2'b00);
    tick(2);
    checkAll("async_e9", 3'b000, 1'b0, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
